// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN_DEFAULT / ADDR_W_DEFAULT : default instruction and PC word-address widths
//   NOP_INSTR                     : canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_state_e                 : fetch FSM states
//   fetch_entry_t                 : queued instruction tagged with its PC
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned ADDR_W_DEFAULT = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    HOLD,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]   instr;
    logic [ADDR_W_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetch entries.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : drop the head this cycle
//   clear      : empty the queue at cycle end (wins over push)
//   head       : entry at the head (undefined when count == 0)
//   count      : number of valid entries
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             clear,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !clear && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch stage between the PC stage and decode.
//   clk, rst    : clock, asynchronous active-high reset
//   pcIn        : current PC word address from the PC stage
//   pcEn        : PC update enable back to the PC stage
//   imemEn      : instruction memory read request
//   imemAddr    : instruction memory word address
//   imemRdata   : read data, valid the cycle after imemEn
//   flush       : taken-branch redirect from execute
//   instrValid  : head of the instruction queue is valid
//   instrReady  : decode accepts the head
//   instrOut    : head instruction (NOP when empty)
//   instrPcOut  : PC of the head instruction (holds last value when empty)
module riscv_ifetch
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcIn,
  output logic              pcEn,
  output logic              imemEn,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [XLEN-1:0]   imemRdata,
  input  logic              flush,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [XLEN-1:0]   instrOut,
  output logic [ADDR_W-1:0] instrPcOut
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic              issue;
  logic              clear;
  logic              push;
  logic              pop;
  logic              inflight;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] last_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  entry_t            head;
  entry_t            push_entry;

  assign instrValid = (count != '0);
  assign pop        = instrValid & instrReady;
  // Entries that will still be held after this cycle's pop, counting the
  // response already on its way back from memory.
  assign occupancy  = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= state_next;
  end

  // imemAddr is forced to zero outside RUN so the reset/HOLD view of the
  // memory interface is all-zero regardless of pcIn.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    clear      = 1'b0;
    pcEn       = 1'b0;
    imemAddr   = '0;
    case (state)
      HOLD: state_next = RUN;
      RUN: begin
        state_next = RUN;
        imemAddr   = pcIn;
        clear      = flush;
        issue      = !flush && (occupancy < (CNT_W + 1)'(DEPTH));
        pcEn       = issue | flush;
      end
    endcase
    imemEn = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      req_pc   <= '0;
    end else begin
      inflight <= issue;
      if (issue) req_pc <= pcIn;
    end
  end

  // A flush in the response cycle drops the returning instruction.
  assign push             = inflight & !clear;
  assign push_entry.instr = imemRdata;
  assign push_entry.pc    = req_pc;

  riscv_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (clear),
    .head      (head),
    .count     (count)
  );

  // Remembers the last presented PC so instrPcOut holds while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last_pc <= '0;
    else if (instrValid) last_pc <= head.pc;
  end

  assign instrOut   = instrValid ? head.instr : XLEN'(NOP_INSTR);
  assign instrPcOut = instrValid ? head.pc : last_pc;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Self-checking bench for riscv_ifetch: PC stage and synchronous memory
// models, an expected-stream scoreboard and directed/random stimulus.
module tb_riscv_ifetch;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] pcIn = '0;
  logic              pcEn;
  logic              imemEn;
  logic [ADDR_W-1:0] imemAddr;
  logic [XLEN-1:0]   imemRdata = '0;
  logic              flush = 1'b0;
  logic              instrValid;
  logic              instrReady = 1'b1;
  logic [XLEN-1:0]   instrOut;
  logic [ADDR_W-1:0] instrPcOut;

  always #5 clk = ~clk;

  riscv_ifetch #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pcIn       (pcIn),
    .pcEn       (pcEn),
    .imemEn     (imemEn),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .flush      (flush),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instrOut   (instrOut),
    .instrPcOut (instrPcOut)
  );

  function automatic logic [XLEN-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h100 + {24'h0, a};
  endfunction

  // Synchronous instruction memory, read latency 1.
  always @(posedge clk) if (imemEn) imemRdata <= mem_word(imemAddr);

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   instr;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_next;
  int                checks = 0;
  int                errors = 0;
  int                accepts = 0;
  int                outstanding = 0;
  int                since_rel = 0;
  logic [ADDR_W-1:0] pc_model = '0;
  logic [ADDR_W-1:0] target = '0;

  logic              o_imemEn, o_pcEn, o_valid, o_pop;
  logic [ADDR_W-1:0] o_addr, o_pc;
  logic [XLEN-1:0]   o_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{exp_next, mem_word(exp_next)});
      exp_next = exp_next + ADDR_W'(1);
    end
  endfunction

  function automatic void restart_stream(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    exp_next = start;
    refill();
  endfunction

  // Monitor: every accepted instruction must be the next one of the stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && instrValid && instrReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_underflow: got pc 0x%0h, expected no instruction", instrPcOut);
        end else begin
          e = exp_q.pop_front();
          check("stream_pc", 32'(instrPcOut), 32'(e.pc));
          check("stream_instr", instrOut, e.instr);
          accepts++;
        end
      end
    end
  end

  // One clock cycle: drive pcIn from the PC model, sample just before the
  // edge, then advance the PC model and the expected stream.
  task automatic tick();
    logic run;
    pcIn = pc_model;
    #4;
    o_imemEn = imemEn;
    o_pcEn   = pcEn;
    o_addr   = imemAddr;
    o_valid  = instrValid;
    o_instr  = instrOut;
    o_pc     = instrPcOut;
    o_pop    = instrValid && instrReady;
    run      = (since_rel >= 1);
    outstanding += int'(o_imemEn) - int'(o_pop);
    if (o_imemEn) begin
      check("issue_addr", 32'(o_addr), 32'(pcIn));
      check("issue_space", 32'(outstanding <= int'(DEPTH)), 32'd1);
    end
    if (flush && run) begin
      check("flush_pcen", 32'(o_pcEn), 32'd1);
      check("flush_no_issue", 32'(o_imemEn), 32'd0);
    end
    if (o_pcEn) pc_model = (flush && run) ? target : pc_model + ADDR_W'(1);
    if (flush && run) begin
      restart_stream(target);
      outstanding = 0;
    end
    refill();
    since_rel++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    pc_model = '0;
    pcIn = '0;
    restart_stream('0);
    outstanding = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    since_rel = 0;
  endtask

  initial begin
    int acc0;
    restart_stream('0);
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_pcen", 32'(pcEn), 32'd0);
    check("rst_imemen", 32'(imemEn), 32'd0);
    check("rst_addr", 32'(imemAddr), 32'd0);
    check("rst_instr", instrOut, NOP);
    check("rst_pc", 32'(instrPcOut), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    since_rel = 0;

    // Startup latency and streaming.
    tick(); check("hold_no_issue", 32'(o_imemEn), 32'd0);
    tick(); check("first_issue", 32'(o_imemEn), 32'd1);
    check("first_addr", 32'(o_addr), 32'd0);
    check("first_valid_early", 32'(o_valid), 32'd0);
    tick(); check("valid_latency", 32'(o_valid), 32'd0);
    tick(); check("first_valid", 32'(o_valid), 32'd1);
    check("first_instr", o_instr, 32'h100);
    check("first_pc", 32'(o_pc), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(); check("stream_no_gap", 32'(o_valid), 32'd1);
    end

    // Backpressure from the first valid.
    do_reset();
    instrReady = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_imemen", 32'(o_imemEn), 32'd0);
      check("bp_pcen", 32'(o_pcEn), 32'd0);
      check("bp_instr", o_instr, 32'h100);
      check("bp_pc", 32'(o_pc), 32'd0);
    end
    instrReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); check("resume_no_gap", 32'(o_valid), 32'd1);
    end

    // Flush with a full queue.
    instrReady = 1'b0;
    repeat (4) tick();
    check("full_no_issue", 32'(o_imemEn), 32'd0);
    flush = 1'b1; target = 8'h20;
    tick();
    flush = 1'b0;
    tick();
    check("post_flush_valid", 32'(o_valid), 32'd0);
    check("post_flush_issue", 32'(o_imemEn), 32'd1);
    check("post_flush_addr", 32'(o_addr), 32'h20);
    instrReady = 1'b1;
    repeat (6) tick();

    // Flush coinciding with a pop in steady streaming.
    repeat (4) tick();
    flush = 1'b1; target = 8'h40;
    tick();
    check("flush_pop", 32'(o_pop), 32'd1);
    flush = 1'b0;
    tick();
    check("post_flush2_valid", 32'(o_valid), 32'd0);
    repeat (6) tick();

    // Random backpressure with occasional redirects.
    acc0 = accepts;
    for (int i = 0; i < 200; i++) begin
      instrReady = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      target = ADDR_W'($urandom);
      tick();
      flush = 1'b0;
    end
    instrReady = 1'b1;
    repeat (6) tick();
    check("random_progress", 32'(accepts - acc0 > 40), 32'd1);

    // Asynchronous reset mid-stream with a request in flight.
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(instrValid), 32'd0);
    check("arst_pcen", 32'(pcEn), 32'd0);
    check("arst_imemen", 32'(imemEn), 32'd0);
    check("arst_addr", 32'(imemAddr), 32'd0);
    check("arst_instr", instrOut, NOP);
    check("arst_pc", 32'(instrPcOut), 32'd0);
    pc_model = '0;
    pcIn = '0;
    restart_stream('0);
    outstanding = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    since_rel = 0;
    tick(); check("arst_hold", 32'(o_imemEn), 32'd0);
    tick(); check("arst_first_issue", 32'(o_imemEn), 32'd1);
    check("arst_first_addr", 32'(o_addr), 32'd0);
    repeat (6) tick();
    check("arst_restart_seen", 32'(exp_next != ADDR_W'(16) || exp_q[0].pc != 8'h0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
